// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory, Ex redirect and IF/ID.
// The master modport is the fetch queue side.
interface instr_fetch_queue_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (
    input  redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_inst, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_i, redirect_pc_i, mem_req_ready, mem_rsp_valid, mem_rsp_inst, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch into a DEPTH-entry {pc, inst} FIFO,
// with flush on redirect and dropping of responses that were in flight at the redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];

  logic [SW-1:0] w_credit_used;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_not_empty;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_drop;
  logic          w_push;

  // Occupancy plus in-flight requests never exceeds DEPTH, so a response always has a slot.
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req_valid   = !rst && !bus.redirect_i && (w_credit_used < SW'(DEPTH));
  assign w_accept      = w_req_valid && bus.mem_req_ready;
  assign w_not_empty   = (r_count != '0);
  assign w_out_valid   = w_not_empty && !bus.redirect_i;
  assign w_pop         = w_out_valid && bus.out_ready;
  assign w_drop        = bus.mem_rsp_valid && (r_drop_cnt != '0);
  assign w_push        = bus.mem_rsp_valid && !w_drop && !bus.redirect_i;

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_pc        = w_not_empty ? r_pc_mem[r_rd_ptr]   : 32'h0;
  assign bus.out_inst      = w_not_empty ? r_inst_mem[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (bus.redirect_i) begin
      // Everything still in flight after this cycle is stale and must be discarded on arrival.
      r_fetch_pc    <= bus.redirect_pc_i;
      r_rsp_pc      <= bus.redirect_pc_i;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(bus.mem_rsp_valid);
      r_drop_cnt    <= r_outstanding - CW'(bus.mem_rsp_valid);
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_accept && !bus.mem_rsp_valid) begin
        r_outstanding <= r_outstanding + CW'(1);
      end else if (!w_accept && bus.mem_rsp_valid) begin
        r_outstanding <= r_outstanding - CW'(1);
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
      r_inst_mem[r_wr_ptr] <= bus.mem_rsp_inst;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order variable-latency memory model, expected-entry scoreboard
// popped by an independent output monitor, and directed phases for stall, redirect, reset and wrap.
module tb_instr_fetch_queue;
  logic clk;
  logic rst;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_pc[$];
  logic [31:0] sb_inst[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          ncyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  logic [31:0] last_acc = 32'h0;
  int          pop_total = 0;
  int          pop_cyc[64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ (pc >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    sb_pc.push_back(pc);
    sb_inst.push_back(inst_of(pc));
  endtask

  // Bounded wait until every expected entry has been consumed by the monitor.
  task automatic wait_sb(input string name);
    int n;
    n = 0;
    while (sb_pc.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, sb_pc.size(), 0);
  endtask

  // Memory model: in-order responses lat windows after acceptance, dropped on reset.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_inst  = 32'h0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        bus.mem_rsp_valid = 1'b0;
      end else if (pend_addr.size() != 0 && pend_due[0] <= ncyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_inst  = inst_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
      #4;
      if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
        pend_addr.push_back(bus.mem_req_addr);
        pend_due.push_back(ncyc + lat);
        acc_cnt++;
        last_acc = bus.mem_req_addr;
        $display("req  addr=%h", bus.mem_req_addr);
        chk("mem_credit_limit", 32'(pend_addr.size() <= 4), 32'd1);
      end
    end
  end

  // Output monitor: every consumed entry must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && bus.out_valid && bus.out_ready) begin
        $display("pop  pc=%h inst=%h", bus.out_pc, bus.out_inst);
        if (sb_pc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected: got pc %h with no entry expected", bus.out_pc);
        end else begin
          chk("mon_pc", bus.out_pc, sb_pc.pop_front());
          chk("mon_inst", bus.out_inst, sb_inst.pop_front());
        end
        pop_cyc[pop_total % 64] = ncyc;
        pop_total++;
      end
    end
  end

  task automatic enter_reset();
    bus.out_ready  = 1'b0;
    bus.redirect_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int p0;
    int a0;
    rst               = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b0;

    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);

    // Streaming with 1-cycle memory and free IF/ID.
    @(negedge clk);
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    lat = 1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #1 base = ncyc;
    p0 = pop_total;
    wait_sb("t1_stream_done");
    chk("t1_first_pop_cycle", 32'(pop_cyc[p0 % 64] - base), 32'd2);
    chk("t1_back_to_back", 32'(pop_cyc[(p0 + 7) % 64] - pop_cyc[p0 % 64]), 32'd7);
    enter_reset();

    // Frozen IF/ID: credits stop fetch at four, then drain without gap.
    lat = 1;
    rst = 1'b0;
    #1 a0 = acc_cnt;
    repeat (10) @(negedge clk);
    #3;
    chk("t2_req_stopped", bus.mem_req_valid, 0);
    chk("t2_accept_count", 32'(acc_cnt - a0), 32'd4);
    chk("t2_last_addr", last_acc, 32'hC);
    @(negedge clk);
    for (int i = 0; i < 5; i++) expect_pc(32'(i * 4));
    bus.out_ready = 1'b1;
    #1 p0 = pop_total;
    wait_sb("t2_drain_done");
    chk("t2_no_gap", 32'(pop_cyc[(p0 + 4) % 64] - pop_cyc[p0 % 64]), 32'd4);
    enter_reset();

    // Redirect with two stale requests in flight at 3-cycle latency.
    for (int i = 0; i < 4; i++) expect_pc(32'h100 + 32'(i * 4));
    lat = 3;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    #1;
    chk("t3_in_flight", pend_addr.size(), 2);
    chk("t3_no_req_on_redirect", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.redirect_i = 1'b0;
    #1 chk("t3_resume_addr", bus.mem_req_addr, 32'h100);
    wait_sb("t3_redirect_done");
    enter_reset();

    // Redirect, response and pop all in one cycle with two entries buffered.
    expect_pc(32'h200);
    expect_pc(32'h204);
    lat = 1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t4_head_valid", bus.out_valid, 1);
    chk("t4_head_pc", bus.out_pc, 32'h0);
    chk("t4_rsp_same_cycle", bus.mem_rsp_valid, 1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    bus.out_ready     = 1'b1;
    #1;
    chk("t4_out_valid_masked", bus.out_valid, 0);
    chk("t4_req_masked", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.redirect_i = 1'b0;
    #1;
    chk("t4_fifo_empty", bus.out_valid, 0);
    chk("t4_new_addr", bus.mem_req_addr, 32'h200);
    chk("t4_new_req", bus.mem_req_valid, 1);
    wait_sb("t4_done");
    enter_reset();

    // Memory back-pressure holds the request at 0x8 for three cycles.
    for (int i = 0; i < 6; i++) expect_pc(32'(i * 4));
    lat = 1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1 a0 = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      chk("t5_hold_valid", bus.mem_req_valid, 1);
      chk("t5_hold_addr", bus.mem_req_addr, 32'h8);
    end
    @(negedge clk);
    bus.mem_req_ready = 1'b1;
    #1 chk("t5_no_accept_in_stall", 32'(acc_cnt - a0), 32'd0);
    @(negedge clk);
    #1;
    chk("t5_single_accept", 32'(acc_cnt - a0), 32'd1);
    chk("t5_next_addr", bus.mem_req_addr, 32'hC);
    wait_sb("t5_done");
    enter_reset();

    // Asynchronous reset while 0x20 sits at the head.
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    lat = 1;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    wait_sb("t6_pre_reset");
    #1;
    chk("t6_head_valid", bus.out_valid, 1);
    chk("t6_head_pc", bus.out_pc, 32'h20);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_out_valid", bus.out_valid, 0);
    chk("t6_async_req_valid", bus.mem_req_valid, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) expect_pc(32'(i * 4));
    rst = 1'b0;
    wait_sb("t6_restart");
    enter_reset();

    // Address wrap past 0xFFFFFFFC, redirect asserted on the first cycle out of reset.
    expect_pc(32'hFFFF_FFF8);
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0);
    expect_pc(32'h4);
    lat = 1;
    bus.out_ready     = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    rst = 1'b0;
    #1 chk("t7_no_req_on_redirect", bus.mem_req_valid, 0);
    @(negedge clk);
    bus.redirect_i = 1'b0;
    #1 chk("t7_wrap_start_addr", bus.mem_req_addr, 32'hFFFF_FFF8);
    wait_sb("t7_wrap_done");
    enter_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
